// File: rtl/req_arbiter8.sv
// Eight-requester arbiter with fixed or round-robin priority, grant hold, and
// forced preemption after MAX_HOLD consecutive granted cycles. All outputs registered.
module req_arbiter8 #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rr_mode,
    input  logic [7:0] req,
    output logic [7:0] grant,
    output logic [2:0] grant_id,
    output logic       grant_valid,
    output logic       preempt
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);

    state_t     state_q, state_d;
    logic [7:0] grant_q, grant_d;
    logic [2:0] grant_id_q, grant_id_d;
    logic       grant_valid_q, grant_valid_d;
    logic       preempt_q, preempt_d;
    logic [2:0] last_id_q, last_id_d;
    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic [2:0] win_s;

    function automatic logic [2:0] fixed_pick(input logic [7:0] r);
        logic [2:0] w;
        w = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (r[i]) begin
                w = 3'(i);
            end else begin
                w = w;
            end
        end
        return w;
    endfunction

    // Downward search starting just below last, so last itself is tried last.
    function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] last);
        logic [2:0] w;
        logic [2:0] idx;
        logic       found;
        w     = 3'd0;
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            idx = last - 3'd1 - 3'(i);
            if (!found && r[idx]) begin
                w     = idx;
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return w;
    endfunction

    // Next-state and next-output computation for the arbitration FSM.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        grant_id_d    = grant_id_q;
        grant_valid_d = grant_valid_q;
        preempt_d     = 1'b0;
        last_id_d     = last_id_q;
        hold_cnt_d    = hold_cnt_q;
        win_s         = rr_mode ? rr_pick(req, last_id_q) : fixed_pick(req);
        case (state_q)
            IDLE: begin
                if (req != 8'h00) begin
                    state_d       = GRANT;
                    grant_d       = 8'h01 << win_s;
                    grant_id_d    = win_s;
                    grant_valid_d = 1'b1;
                    last_id_d     = win_s;
                    hold_cnt_d    = 8'd1;
                end else begin
                    state_d       = IDLE;
                end
            end
            GRANT: begin
                if (!req[grant_id_q]) begin
                    state_d       = IDLE;
                    grant_d       = 8'h00;
                    grant_valid_d = 1'b0;
                end else if (hold_cnt_q == HOLD_LIMIT) begin
                    state_d       = IDLE;
                    grant_d       = 8'h00;
                    grant_valid_d = 1'b0;
                    preempt_d     = 1'b1;
                end else begin
                    hold_cnt_d    = hold_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d       = IDLE;
                grant_d       = 8'h00;
                grant_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            grant_q       <= 8'h00;
            grant_id_q    <= 3'd0;
            grant_valid_q <= 1'b0;
            preempt_q     <= 1'b0;
            last_id_q     <= 3'd0;
            hold_cnt_q    <= 8'd0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            grant_id_q    <= grant_id_d;
            grant_valid_q <= grant_valid_d;
            preempt_q     <= preempt_d;
            last_id_q     <= last_id_d;
            hold_cnt_q    <= hold_cnt_d;
        end
    end

    assign grant       = grant_q;
    assign grant_id    = grant_id_q;
    assign grant_valid = grant_valid_q;
    assign preempt     = preempt_q;

endmodule

// File: tb/tb_req_arbiter8.sv
// Scoreboard bench for req_arbiter8: two instances (MAX_HOLD 4 and 3) share inputs;
// each queued expectation names the instance it applies to.
module tb_req_arbiter8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rr_mode = 1'b0;
    logic [7:0] req = 8'h00;

    logic [7:0] grant_a, grant_b;
    logic [2:0] grant_id_a, grant_id_b;
    logic       grant_valid_a, grant_valid_b;
    logic       preempt_a, preempt_b;

    typedef struct {
        int         sel;
        logic [7:0] g;
        logic [2:0] id;
        logic       v;
        logic       p;
        string      name;
    } exp_t;

    exp_t sb_q[$];
    int   dut_sel = 0;
    int   n_pass = 0;
    int   n_total = 0;
    logic [2:0] rr_id;

    always #5 clk = ~clk;

    req_arbiter8 #(.MAX_HOLD(4)) u_dut_a (
        .clk(clk), .rst(rst), .rr_mode(rr_mode), .req(req),
        .grant(grant_a), .grant_id(grant_id_a), .grant_valid(grant_valid_a), .preempt(preempt_a)
    );

    req_arbiter8 #(.MAX_HOLD(3)) u_dut_b (
        .clk(clk), .rst(rst), .rr_mode(rr_mode), .req(req),
        .grant(grant_b), .grant_id(grant_id_b), .grant_valid(grant_valid_b), .preempt(preempt_b)
    );

    // Drive one cycle of inputs and queue the outputs expected after the next edge.
    task automatic cyc(input logic r, input logic rr, input logic [7:0] rq,
                       input logic [7:0] eg, input logic [2:0] eid,
                       input logic ev, input logic ep, input string nm);
        exp_t e;
        @(negedge clk);
        rst     = r;
        rr_mode = rr;
        req     = rq;
        e.sel   = dut_sel;
        e.g     = eg;
        e.id    = eid;
        e.v     = ev;
        e.p     = ep;
        e.name  = nm;
        sb_q.push_back(e);
    endtask

    // Monitor: after each active edge, pop one expectation and compare.
    initial begin
        exp_t       e;
        logic [7:0] ag;
        logic [2:0] aid;
        logic       av, ap;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                if (e.sel == 0) begin
                    ag = grant_a; aid = grant_id_a; av = grant_valid_a; ap = preempt_a;
                end else begin
                    ag = grant_b; aid = grant_id_b; av = grant_valid_b; ap = preempt_b;
                end
                n_total++;
                if (ag === e.g && aid === e.id && av === e.v && ap === e.p) begin
                    n_pass++;
                end else begin
                    $display("FAIL %s (dut %0d): got grant=%h id=%0d valid=%b preempt=%b, expected grant=%h id=%0d valid=%b preempt=%b",
                             e.name, e.sel, ag, aid, av, ap, e.g, e.id, e.v, e.p);
                end
            end
        end
    end

    initial begin
        // Reset held with all requests active, then first fixed-priority grant
        dut_sel = 0;
        cyc(1'b1, 1'b0, 8'hFF, 8'h00, 3'd0, 1'b0, 1'b0, "reset0");
        cyc(1'b1, 1'b0, 8'hFF, 8'h00, 3'd0, 1'b0, 1'b0, "reset1");
        cyc(1'b0, 1'b0, 8'hFF, 8'h80, 3'd7, 1'b1, 1'b0, "post_reset_grant");
        cyc(1'b0, 1'b0, 8'h00, 8'h00, 3'd7, 1'b0, 1'b0, "release7");
        cyc(1'b0, 1'b0, 8'h00, 8'h00, 3'd7, 1'b0, 1'b0, "idle_hold_id");

        // Fixed priority, lower request ignored while granted
        cyc(1'b0, 1'b0, 8'h05, 8'h04, 3'd2, 1'b1, 1'b0, "fixed_05");
        cyc(1'b0, 1'b0, 8'h05, 8'h04, 3'd2, 1'b1, 1'b0, "fixed_05_hold");
        cyc(1'b0, 1'b0, 8'h05, 8'h04, 3'd2, 1'b1, 1'b0, "fixed_05_hold");
        cyc(1'b0, 1'b0, 8'h01, 8'h00, 3'd2, 1'b0, 1'b0, "fixed_drop_gap");
        cyc(1'b0, 1'b0, 8'h01, 8'h01, 3'd0, 1'b1, 1'b0, "fixed_01");
        cyc(1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, "fixed_01_rel");

        // Round-robin rotation with MAX_HOLD=4
        cyc(1'b1, 1'b1, 8'hFF, 8'h00, 3'd0, 1'b0, 1'b0, "rr_reset");
        for (int k = 0; k < 9; k++) begin
            rr_id = 3'(7 - (k % 8));
            for (int c = 0; c < 4; c++) begin
                cyc(1'b0, 1'b1, 8'hFF, 8'h01 << rr_id, rr_id, 1'b1, 1'b0, "rr_hold");
            end
            cyc(1'b0, 1'b1, 8'hFF, 8'h00, rr_id, 1'b0, 1'b1, "rr_preempt");
        end
        cyc(1'b0, 1'b0, 8'h00, 8'h00, 3'd7, 1'b0, 1'b0, "rr_end_idle");

        // Fixed-mode timeout with MAX_HOLD=3
        dut_sel = 1;
        cyc(1'b1, 1'b0, 8'h10, 8'h00, 3'd0, 1'b0, 1'b0, "to_reset");
        for (int p = 0; p < 3; p++) begin
            for (int c = 0; c < 3; c++) begin
                cyc(1'b0, 1'b0, 8'h10, 8'h10, 3'd4, 1'b1, 1'b0, "to_hold");
            end
            cyc(1'b0, 1'b0, 8'h10, 8'h00, 3'd4, 1'b0, 1'b1, "to_preempt");
        end
        cyc(1'b0, 1'b0, 8'h00, 8'h00, 3'd4, 1'b0, 1'b0, "to_idle");

        // Early release, fixed mode then round-robin
        dut_sel = 0;
        cyc(1'b1, 1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, "er_reset");
        cyc(1'b0, 1'b0, 8'h0A, 8'h08, 3'd3, 1'b1, 1'b0, "er_grant3");
        cyc(1'b0, 1'b0, 8'h0A, 8'h08, 3'd3, 1'b1, 1'b0, "er_hold3");
        cyc(1'b0, 1'b0, 8'h02, 8'h00, 3'd3, 1'b0, 1'b0, "er_release");
        cyc(1'b0, 1'b0, 8'h02, 8'h02, 3'd1, 1'b1, 1'b0, "er_grant1");
        cyc(1'b0, 1'b0, 8'h00, 8'h00, 3'd1, 1'b0, 1'b0, "er_rel1");
        cyc(1'b1, 1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, "er_rr_reset");
        cyc(1'b0, 1'b1, 8'h0A, 8'h08, 3'd3, 1'b1, 1'b0, "er_rr_grant3");
        cyc(1'b0, 1'b1, 8'h0A, 8'h08, 3'd3, 1'b1, 1'b0, "er_rr_hold3");
        cyc(1'b0, 1'b1, 8'h02, 8'h00, 3'd3, 1'b0, 1'b0, "er_rr_release");
        cyc(1'b0, 1'b1, 8'h0A, 8'h02, 3'd1, 1'b1, 1'b0, "er_rr_next1");
        cyc(1'b0, 1'b1, 8'h00, 8'h00, 3'd1, 1'b0, 1'b0, "er_rr_rel1");

        // Reset mid-grant clears last_id so the RR search restarts at 7
        cyc(1'b0, 1'b1, 8'h20, 8'h20, 3'd5, 1'b1, 1'b0, "mid_grant5");
        cyc(1'b0, 1'b1, 8'h20, 8'h20, 3'd5, 1'b1, 1'b0, "mid_hold5");
        cyc(1'b1, 1'b1, 8'h20, 8'h00, 3'd0, 1'b0, 1'b0, "mid_reset");
        cyc(1'b0, 1'b1, 8'h21, 8'h20, 3'd5, 1'b1, 1'b0, "mid_rr_from7");
        cyc(1'b0, 1'b1, 8'h00, 8'h00, 3'd5, 1'b0, 1'b0, "mid_rel");

        @(negedge clk);
        @(negedge clk);
        n_total++;
        if (sb_q.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL drain: got %0d pending expectations, expected 0", sb_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
